// File: rtl/ws2812_frame_loader.sv
// rtl/ws2812_frame_loader.sv - pixel stream to WS2812 pixel RAM loader with frame start/hold control
// Optional feature macro: LOADER_BRIGHTNESS_EN (iBrightness port plus one channel-scaling pipeline stage)
module ws2812_frame_loader #(
  parameter int DATAWIDTH         = 32,
  parameter int ADDRESSWIDTH      = 6,
  parameter int START_ADDRESS     = 12,
  parameter int MAX_LEDS          = 64,
  parameter int FRAME_HOLD_CYCLES = 200000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             iNumLeds,
  input  logic                    iPixelValid,
  input  logic [23:0]             iPixelData,
  input  logic                    iPixelLast,
`ifdef LOADER_BRIGHTNESS_EN
  input  logic [7:0]              iBrightness,
`endif
  output logic                    oPixelReady,
  output logic                    oWriteEn,
  output logic [ADDRESSWIDTH-1:0] oWriteAddress,
  output logic [DATAWIDTH-1:0]    oWriteData,
  output logic [31:0]             oConfig,
  output logic                    oBusy,
  output logic                    oShortFrame,
  output logic                    oLongFrame
);

  localparam int HW = (FRAME_HOLD_CYCLES > 1) ? $clog2(FRAME_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(FRAME_HOLD_CYCLES - 1);
  localparam logic [ADDRESSWIDTH-1:0] START_A = ADDRESSWIDTH'(START_ADDRESS);
  localparam logic [15:0] MAX_L = 16'(MAX_LEDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_END, S_HOLD} state_t;

  state_t                  state;
  logic [15:0]             index;
  logic [15:0]             count_reg;
  logic [15:0]             clamp_count;
  logic [15:0]             cur_index;
  logic [15:0]             cur_count;
  logic                    cfg_start;
  logic [HW-1:0]           hold_cnt;
  logic                    accept;
  logic                    at_end;
  logic                    drained;
  logic                    s1_valid;
  logic                    s1_short;
  logic                    s1_long;
  logic [ADDRESSWIDTH-1:0] s1_addr;
  logic [23:0]             s1_pix;

  // In IDLE the frame has not been latched yet, so the live strip length applies to pixel 0
  always_comb begin
    clamp_count = (iNumLeds > MAX_L) ? MAX_L : iNumLeds;
    cur_index   = (state == S_IDLE) ? 16'd0 : index;
    cur_count   = (state == S_IDLE) ? clamp_count : count_reg;
    accept      = iPixelValid & oPixelReady;
    at_end      = (cur_index == cur_count - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      index       <= 16'd0;
      count_reg   <= 16'd0;
      cfg_start   <= 1'b0;
      hold_cnt    <= '0;
      oPixelReady <= 1'b0;
      s1_valid    <= 1'b0;
      s1_short    <= 1'b0;
      s1_long     <= 1'b0;
      s1_addr     <= '0;
      s1_pix      <= 24'd0;
    end else begin
      s1_valid <= 1'b0;
      s1_short <= 1'b0;
      s1_long  <= 1'b0;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_addr  <= START_A + cur_index[ADDRESSWIDTH-1:0];
        s1_pix   <= iPixelData;
        index    <= cur_index + 16'd1;
        if (state == S_IDLE) count_reg <= clamp_count;
        if (at_end) begin
          state       <= S_END;
          oPixelReady <= 1'b0;
          s1_long     <= !iPixelLast;
        end else if (iPixelLast) begin
          state       <= S_PAD;
          oPixelReady <= 1'b0;
          s1_short    <= 1'b1;
        end else begin
          state       <= S_LOAD;
          oPixelReady <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: oPixelReady <= (clamp_count != 16'd0);
          S_LOAD: oPixelReady <= 1'b1;
          S_PAD: begin
            s1_valid <= 1'b1;
            s1_addr  <= START_A + index[ADDRESSWIDTH-1:0];
            s1_pix   <= 24'd0;
            index    <= index + 16'd1;
            if (index == count_reg - 16'd1) state <= S_END;
          end
          S_END: begin
            if (drained) begin
              cfg_start <= 1'b1;
              hold_cnt  <= HOLD_LOAD;
              state     <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              cfg_start   <= 1'b0;
              state       <= S_IDLE;
              oPixelReady <= (clamp_count != 16'd0);
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LOADER_BRIGHTNESS_EN
  logic [7:0] bright_reg;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'(b);
    return p[15:8];
  endfunction

  // Pulses ride the pipeline so they stay aligned with the terminating pixel's write
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_reg    <= 8'd0;
      oWriteEn      <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oShortFrame   <= 1'b0;
      oLongFrame    <= 1'b0;
    end else begin
      if (accept && state == S_IDLE) bright_reg <= iBrightness;
      oWriteEn      <= s1_valid;
      oWriteAddress <= s1_addr;
      oWriteData    <= DATAWIDTH'({scale(s1_pix[23:16], bright_reg),
                                   scale(s1_pix[15:8], bright_reg),
                                   scale(s1_pix[7:0], bright_reg)});
      oShortFrame   <= s1_short;
      oLongFrame    <= s1_long;
    end
  end

  assign drained = !s1_valid;
`else
  assign oWriteEn      = s1_valid;
  assign oWriteAddress = s1_addr;
  assign oWriteData    = DATAWIDTH'(s1_pix);
  assign oShortFrame   = s1_short;
  assign oLongFrame    = s1_long;
  assign drained       = 1'b1;
`endif

  assign oConfig = {cfg_start, 15'd0, count_reg};
  assign oBusy   = (state != S_IDLE);

endmodule

// File: tb/tb_ws2812_frame_loader.sv
// tb/tb_ws2812_frame_loader.sv - self-checking bench for ws2812_frame_loader (optional LOADER_BRIGHTNESS_EN)
module tb_ws2812_frame_loader;
  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iNumLeds;
  logic        iPixelValid;
  logic [23:0] iPixelData;
  logic        iPixelLast;
  logic [7:0]  bright;
`ifdef LOADER_BRIGHTNESS_EN
  logic [7:0]  iBrightness;
`endif
  logic        oPixelReady, oWriteEn, oBusy, oShortFrame, oLongFrame;
  logic [5:0]  oWriteAddress;
  logic [31:0] oWriteData, oConfig;

  always #5 clk = ~clk;

  ws2812_frame_loader #(.FRAME_HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .iNumLeds(iNumLeds), .iPixelValid(iPixelValid),
    .iPixelData(iPixelData), .iPixelLast(iPixelLast),
`ifdef LOADER_BRIGHTNESS_EN
    .iBrightness(iBrightness),
`endif
    .oPixelReady(oPixelReady), .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress),
    .oWriteData(oWriteData), .oConfig(oConfig), .oBusy(oBusy),
    .oShortFrame(oShortFrame), .oLongFrame(oLongFrame));

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    bit          s;
    bit          l;
    bit          fin;
  } wr_t;

  wr_t         exp_q[$];
  int          exp_cnt_q[$];
  logic [23:0] stim[$];
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_short_seen = 0;
  int          n_long_seen = 0;
  logic [31:0] cfg_at_rise = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    return 24'h010203 + 24'(i) * 24'h010101;
  endfunction

  function automatic logic [31:0] expd(input logic [23:0] p);
`ifdef LOADER_BRIGHTNESS_EN
    int g, r, b;
    g = (int'(p[23:16]) * int'(bright)) / 256;
    r = (int'(p[15:8]) * int'(bright)) / 256;
    b = (int'(p[7:0]) * int'(bright)) / 256;
    return {8'h00, 8'(g), 8'(r), 8'(b)};
`else
    return {8'h00, p};
`endif
  endfunction

  // Frame model: split the stream into frames by length/last rules and list every RAM write
  task automatic model(input int n, input int lastpos);
    int  count, idx;
    wr_t e;
    count = (n > 64) ? 64 : n;
    idx = 0;
    for (int p = 0; p < stim.size(); p++) begin
      e.addr = 6'((12 + idx) % 64);
      e.data = expd(stim[p]);
      e.s = 0; e.l = 0; e.fin = 0;
      if (idx == count - 1) begin
        e.l = (p != lastpos);
        e.fin = 1;
        exp_q.push_back(e);
        exp_cnt_q.push_back(count);
        idx = 0;
      end else if (p == lastpos) begin
        e.s = 1;
        exp_q.push_back(e);
        for (int j = idx + 1; j < count; j++) begin
          e.addr = 6'((12 + j) % 64);
          e.data = 32'h0;
          e.s = 0;
          e.fin = (j == count - 1);
          exp_q.push_back(e);
        end
        exp_cnt_q.push_back(count);
        idx = 0;
      end else begin
        exp_q.push_back(e);
        idx++;
      end
    end
  endtask

  // Per-cycle compare against the model
  bit   prev_start = 0;
  bit   rise_due = 0;
  int   high_len = 0;
  logic [15:0] held_cnt = 0;
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("cfg_zero_bits", oConfig[30:16], 0);
      if (oWriteEn || oConfig[31]) chk("busy_active", oBusy, 1);
      if (rise_due) begin
        chk("start_after_last_write", {oConfig[31], prev_start}, 2'b10);
        rise_due = 0;
      end
      if (oShortFrame) n_short_seen++;
      if (oLongFrame) n_long_seen++;
      if (oWriteEn) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", oWriteAddress, e.addr);
          chk("wr_data", oWriteData, e.data);
          chk("short_pulse", oShortFrame, e.s);
          chk("long_pulse", oLongFrame, e.l);
          log_addr.push_back(oWriteAddress);
          log_data.push_back(oWriteData);
          if (e.fin) rise_due = 1;
        end
      end else begin
        chk("no_pulse_without_write", {oShortFrame, oLongFrame}, 0);
      end
      if (oConfig[31] && !prev_start) begin
        if (exp_cnt_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("cfg_count", oConfig[15:0], 64'(exp_cnt_q.pop_front()));
        cfg_at_rise = oConfig;
        held_cnt = oConfig[15:0];
        high_len = 1;
      end else if (oConfig[31]) begin
        high_len++;
        chk("cfg_count_stable", oConfig[15:0], held_cnt);
      end
      if (!oConfig[31] && prev_start) chk("hold_length", high_len, HOLD);
      if (oConfig[31]) chk("ready_low_in_hold", oPixelReady, 0);
      prev_start = oConfig[31];
    end else begin
      prev_start = 0;
      rise_due = 0;
      high_len = 0;
    end
  end

  task automatic send_pix(input logic [23:0] d, input logic l);
    iPixelValid = 1; iPixelData = d; iPixelLast = l;
    for (int k = 0; ; k++) begin
      if (oPixelReady) begin
        @(posedge clk);
        break;
      end
      if (k > 300) begin
        chk("accept_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    iPixelValid = 0; iPixelLast = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!oBusy && exp_q.size() == 0 && exp_cnt_q.size() == 0) return;
    end
    chk("frame_done_timeout", 1, 0);
  endtask

  task automatic run_stream(input int n, input int lastpos);
    iNumLeds = 16'(n);
    log_addr.delete(); log_data.delete();
    n_short_seen = 0; n_long_seen = 0;
    model(n, lastpos);
    for (int p = 0; p < stim.size(); p++) send_pix(stim[p], p == lastpos);
    wait_done();
  endtask

  task automatic fill(input int npix);
    stim.delete();
    for (int i = 0; i < npix; i++) stim.push_back(pix(i));
  endtask

  task automatic reset_check(input string name);
    mon_en = 0;
    iPixelValid = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_cfg"}, oConfig, 0);
    chk({name, "_data"}, oWriteData, 0);
    chk({name, "_ctrl"}, {oWriteEn, oWriteAddress, oBusy, oShortFrame, oLongFrame, oPixelReady}, 0);
    reset = 0;
    @(negedge clk);
    chk({name, "_ready"}, {oPixelReady, oBusy}, 2'b10);
    exp_q.delete(); exp_cnt_q.delete();
    mon_en = 1;
  endtask

  initial begin
    reset = 1; iNumLeds = 8; iPixelValid = 0; iPixelData = 0; iPixelLast = 0; bright = 8'hFF;
`ifdef LOADER_BRIGHTNESS_EN
    iBrightness = bright;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cfg", oConfig, 0);
    chk("reset_ctrl", {oWriteEn, oWriteAddress, oBusy, oShortFrame, oLongFrame, oPixelReady}, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", oPixelReady, 1);
    mon_en = 1;

    fill(8);
    run_stream(8, 7);
    chk("t1_cfg", cfg_at_rise, 32'h8000_0008);
    chk("t1_nwrites", log_addr.size(), 8);
    chk("t1_first_addr", log_addr[0], 12);
    chk("t1_last_addr", log_addr[7], 19);
    chk("t1_pulses", n_short_seen + n_long_seen, 0);
`ifndef LOADER_BRIGHTNESS_EN
    chk("t1_first_data", log_data[0], 32'h0001_0203);
    chk("t1_last_data", log_data[7], 32'h0008_090A);
`endif

    fill(3);
    run_stream(8, 2);
    chk("t2_short", n_short_seen, 1);
    chk("t2_nwrites", log_addr.size(), 8);
    chk("t2_pad_first", {log_addr[3], log_data[3]}, {6'd15, 32'h0});
    chk("t2_pad_last", {log_addr[7], log_data[7]}, {6'd19, 32'h0});
    chk("t2_cfg", cfg_at_rise, 32'h8000_0008);

    fill(8);
    run_stream(4, 7);
    chk("t3_long", n_long_seen, 1);
    chk("t3_nwrites", log_addr.size(), 8);
    chk("t3_next_frame_addr", {log_addr[4], log_addr[5]}, {6'd12, 6'd13});
    chk("t3_cfg", cfg_at_rise, 32'h8000_0004);
`ifndef LOADER_BRIGHTNESS_EN
    chk("t3_carry_data", log_data[4], 32'h0005_0607);
`endif

    fill(64);
    run_stream(100, 63);
    chk("t4_cfg", cfg_at_rise, 32'h8000_0040);
    chk("t4_nwrites", log_addr.size(), 64);
    chk("t4_addr_51", log_addr[51], 63);
    chk("t4_addr_52", log_addr[52], 0);

    fill(2);
    iNumLeds = 2;
    model(2, 1);
    send_pix(stim[0], 0);
    send_pix(stim[1], 1);
    for (int k = 0; k < 50 && !oConfig[31]; k++) @(negedge clk);
    chk("t5_hold_reached", oConfig[31], 1);
    repeat (3) @(negedge clk);
    reset_check("t5_hold_reset");

    iNumLeds = 8;
    mon_en = 0;
    for (int i = 0; i < 3; i++) send_pix(pix(i), 0);
    chk("t5_in_load", {oBusy, oPixelReady}, 2'b11);
    reset_check("t5_load_reset");

    fill(4);
    run_stream(4, 3);
    chk("t5_recover_cfg", cfg_at_rise, 32'h8000_0004);

`ifdef LOADER_BRIGHTNESS_EN
    bright = 8'h80;
    iBrightness = bright;
    stim.delete();
    stim.push_back(24'hFF4002);
    run_stream(1, 0);
    chk("t6_scaled", log_data[0], 32'h007F_2001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
